parallel_accumulator: RTL and testbench
=======================================

# parallel_accumulator

Parametrised single-clock reduction engine: accepts a stream of operands over a valid/ready handshake into an internal operand pool, then reduces the pool pairwise using NUM_PROC parallel processing lanes under round-robin arbitration until one value remains. Supports sum (modulo 2^WIDTH, sticky overflow) and unsigned-max modes. Successor to the fixed 4-processor, 32-bit shared-bus accumulator subsystem; it replaces that subsystem's tristate bus with point-to-point ports and adds backpressure and result handshaking.

## Interface
- WIDTH, 32: operand/result width in bits.
- DEPTH, 1024: operand pool capacity (entries), ≥2.
- NUM_PROC, 4: number of reduction lanes, ≥1.
- PROC_LAT, 2: lane latency in cycles from issue to writeback, ≥1.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_data  in  WIDTH  operand.
- in_last  in  1  qualifies the final operand of a job; meaningful only when in_valid.
- in_ready  out  1  pool accepts an operand this cycle.
- mode  in  1  0 = sum, 1 = unsigned max; sampled on the first accepted operand of a job.
- result  out  WIDTH  reduced value; valid only while result_valid.
- result_valid  out  1  result available; held until acknowledged.
- result_ack  in  1  consumer takes result.
- overflow  out  1  sticky sum carry-out for the current job; 0 in max mode.
- busy  out  1  high in LOAD, REDUCE, DONE.

## Operation
- Reset (reset low, asynchronous): state IDLE; pool empty (count 0, pointers 0); all lanes idle; arbiter pointer to lane 0; in_ready=1, result_valid=0, result=0, overflow=0, busy=0. Reset mid-job discards all operands and in-flight lane work.
- Pool: circular buffer, DEPTH entries, one pair-pop port (two head entries) and one push port per cycle; count = entries stored.
- IDLE: in_ready=1. Accepted operand (in_valid & in_ready) is pushed, mode latched, overflow cleared; -> LOAD, or -> REDUCE if in_last on that beat.
- LOAD: in_ready = (count < DEPTH). Each accepted operand pushed; accept with in_last -> REDUCE. When count == DEPTH, in_ready=0 and the source stalls; no operand is dropped or overwritten.
- REDUCE: in_ready=0. Each cycle, if count ≥ 2 and at least one lane idle, issue one pair: pop head two entries, grant to the first idle lane at or after the round-robin pointer, pointer advances to granted lane+1 (mod NUM_PROC). At most one issue per cycle.
- Lane: computes a+b (WIDTH-bit, wrap) or max(a,b) (unsigned); result pushed to pool tail exactly PROC_LAT cycles after issue. Sum carry-out sets overflow (sticky until next job). Because issues are one per cycle with fixed latency, at most one lane writes back per cycle; no writeback arbitration.
- Simultaneous pop and push in one cycle allowed: count changes by −1. Push never exceeds DEPTH (reduction only decreases count).
- REDUCE -> DONE when count == 1, no lane busy, no push pending. A single-operand job goes straight to DONE with no lane activity.
- DONE: result = remaining pool entry, result_valid=1, busy=1. On result_ack: pool cleared, -> IDLE, result_valid=0 next cycle. result_ack outside DONE is ignored.
- in_valid in REDUCE/DONE is ignored (in_ready=0).

## Timing
- Operand accepted on the edge where in_valid & in_ready; visible in count next cycle.
- First issue no earlier than the cycle after the in_last beat.
- Issue at edge t -> lane result in pool at edge t+PROC_LAT; eligible for re-pairing from the cycle after.
- result_valid rises the cycle after the final writeback (or the cycle after the in_last beat for one operand).
- in_ready rises the cycle after result_ack is sampled in DONE.
- overflow valid with result_valid; unchanged until the next job's first accepted operand.

## Test plan
- Sum: mode=0, operands 1..8 (in_last on 8), ack immediately -> result=36, overflow=0, all four lanes granted at least once in rotation 0,1,2,3.
- Max: mode=1, operands 5, 17, 3, 9 -> result=17, overflow=0.
- Overflow: mode=0, WIDTH=32, operands 0xFFFFFFFF, 0x00000001 -> result=0x00000000, overflow=1; next job 2,3 -> result=5, overflow=0.
- Single operand 0x1234 with in_last -> result_valid with result=0x1234, no lane issued; hold result_ack low 10 cycles -> result_valid and result stay stable, in_ready=0.
- Full/backpressure: DEPTH=4, in_valid held with 6 operands -> in_ready=0 after 4th accept, no further accepts; (job with in_last on 4th: 10,20,30,40 -> 100).
- Reset mid-REDUCE: 16-operand job, assert reset low during REDUCE -> all outputs at reset values immediately; subsequent job 7,8 -> result=15.

Source files
------------

// File: rtl/parallel_accumulator.sv
// parallel_accumulator: streamed operand pool reduced pairwise by NUM_PROC round-robin lanes (sum or unsigned max)
//   clk, reset (async active-low)
//   in_valid/in_data/in_last/in_ready : operand stream into the pool; mode latched on first operand of a job
//   result/result_valid/result_ack    : reduced value, held until acknowledged
//   overflow : sticky sum carry-out of the current job; busy : job in progress
module parallel_accumulator #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int NUM_PROC = 4,
  parameter int PROC_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overflow,
  output logic             busy
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);
  localparam int LW  = NUM_PROC > 1 ? $clog2(NUM_PROC) : 1;
  localparam int CW  = PROC_LAT > 1 ? $clog2(PROC_LAT) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, REDUCE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_n;
  logic [CNW-1:0] count_q, count_d;
  logic mode_q, mode_d, ovf_q, ovf_d;
  logic [LW-1:0] rr_q, rr_d, grant;
  logic found;
  logic [NUM_PROC-1:0] busy_q, cy_q, wb;
  logic [CW-1:0] cnt_q [NUM_PROC];
  logic [WIDTH-1:0] res_q [NUM_PROC];
  logic [WIDTH-1:0] op_a, op_b, op_r, wb_data, push_data;
  logic [WIDTH:0] sum;
  logic accept, issue, push, wb_any, wb_cy, clear, lanes_after;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // pair operands are the two head entries; lanes capture the result at issue
  assign head_n = nxt(head_q);
  assign op_a = mem[head_q];
  assign op_b = mem[head_n];
  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign op_r = mode_q ? (op_a > op_b ? op_a : op_b) : sum[WIDTH-1:0];

  assign in_ready = state_q == IDLE || (state_q == LOAD && count_q < CNW'(DEPTH));
  assign accept = in_valid && in_ready;
  assign issue = state_q == REDUCE && count_q >= CNW'(2) && found;
  assign push = accept || wb_any;
  assign push_data = accept ? in_data : wb_data;
  assign clear = state_q == DONE && result_ack;
  // lanes that will still hold work after this edge
  assign lanes_after = (|(busy_q & ~wb)) || issue;
  assign wb_any = |wb;

  assign result = state_q == DONE ? op_a : '0;
  assign result_valid = state_q == DONE;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;

  // first idle lane at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      if (!found && !busy_q[LW'((int'(rr_q) + k) % NUM_PROC)]) begin
        found = 1'b1;
        grant = LW'((int'(rr_q) + k) % NUM_PROC);
      end
    end
  end

  // issues are one per cycle with fixed latency, so at most one lane is in wb
  always_comb begin
    wb = '0;
    wb_data = '0;
    wb_cy = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      wb[i] = busy_q[i] && cnt_q[i] == '0;
      wb_data |= wb[i] ? res_q[i] : '0;
      wb_cy |= wb[i] & cy_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d = (state_q == IDLE && accept) ? mode : mode_q;
    ovf_d = (state_q == IDLE && accept) ? 1'b0 : ovf_q | (wb_any & wb_cy);
    head_d = clear ? '0 : issue ? nxt(head_n) : head_q;
    tail_d = clear ? '0 : push ? nxt(tail_q) : tail_q;
    count_d = clear ? '0 : count_q + CNW'(push) - (issue ? CNW'(2) : CNW'(0));
    rr_d = issue ? (grant == LW'(NUM_PROC - 1) ? '0 : grant + 1'b1) : rr_q;
    case (state_q)
      IDLE:    state_d = accept ? (in_last ? DONE : LOAD) : IDLE;
      LOAD:    state_d = (accept && in_last) ? REDUCE : LOAD;
      REDUCE:  state_d = (count_d == CNW'(1) && !lanes_after) ? DONE : REDUCE;
      DONE:    state_d = result_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      mode_q <= 1'b0;
      ovf_q <= 1'b0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      mode_q <= mode_d;
      ovf_q <= ovf_d;
      rr_q <= rr_d;
    end
  end

  // pool storage needs no reset: entries are only read while count covers them
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cy_q <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PROC; i++) begin
        if (issue && grant == LW'(i)) begin
          busy_q[i] <= 1'b1;
          cnt_q[i] <= CW'(PROC_LAT - 1);
          res_q[i] <= op_r;
          cy_q[i] <= !mode_q && sum[WIDTH];
        end else if (busy_q[i]) begin
          busy_q[i] <= cnt_q[i] != '0;
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_parallel_accumulator.sv
// tb_parallel_accumulator: randomized jobs against a whole-job reference model with a decoupled result scoreboard
module tb_parallel_accumulator;
  localparam int W = 32;
  localparam int D = 16;
  localparam int NP = 4;
  localparam int PL = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic mode = 1'b0;
  logic result_ack = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, result_valid, overflow, busy;
  logic [W-1:0] result;
  int checks = 0;
  int fails = 0;
  typedef struct packed {logic [W-1:0] r; logic o;} exp_t;
  exp_t sb[$];
  logic [W-1:0] ops[$];
  logic rv_prev = 1'b0;
  logic [W-1:0] held = '0;

  always #5 clk = ~clk;

  parallel_accumulator #(.WIDTH(W), .DEPTH(D), .NUM_PROC(NP), .PROC_LAT(PL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // whole-job reference: true sum overflows iff any pairwise carry occurred
  function automatic exp_t model(input logic m);
    logic [63:0] s = '0;
    logic [W-1:0] mx = '0;
    exp_t e;
    foreach (ops[i]) begin
      s += 64'(ops[i]);
      if (ops[i] > mx) mx = ops[i];
    end
    e.r = m ? mx : s[W-1:0];
    e.o = !m && (s >> W) != 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got %h with no job outstanding", result);
      end else begin
        chk("result", result, sb[0].r);
        chk("overflow", W'(overflow), W'(sb[0].o));
        sb.delete(0);
      end
    end else if (result_valid) chk("result_hold", result, held);
    rv_prev <= result_valid;
    held <= result;
  end

  task automatic check_reset();
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_result_valid", W'(result_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", W'(overflow), 0);
    chk("rst_busy", W'(busy), 0);
  endtask

  task automatic send_op(input logic [W-1:0] d, input logic l, input logic m);
    int t = 0;
    logic rdy;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    mode = m;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        fail_now("accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_job(input logic m, input int ack_dly, input bit abort);
    int n = ops.size();
    int t = 0;
    if (!abort) sb.push_back(model(m));
    for (int i = 0; i < n; i++) begin
      result_ack = 1'($urandom_range(0, 1));
      send_op(ops[i], i == n - 1, i == 0 ? m : 1'($urandom_range(0, 1)));
      result_ack = 1'b0;
      if (i != n - 1) repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    if (abort) return;
    do begin
      @(negedge clk);
      t++;
    end while (!result_valid && t < 500);
    if (!result_valid) fail_now("result_timeout");
    if (n == 1) chk("single_latency", W'(t), 1);
    repeat (ack_dly) begin
      @(negedge clk);
      chk("done_in_ready", W'(in_ready), 0);
      chk("done_busy", W'(busy), 1);
      chk("done_valid", W'(result_valid), 1);
    end
    @(posedge clk);
    #1;
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    chk("ready_after_ack", W'(in_ready), 1);
    chk("valid_after_ack", W'(result_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic m;
    #12;
    check_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ops.delete();
    for (int i = 1; i <= 8; i++) ops.push_back(W'(i));
    run_job(1'b0, 0, 0);
    ops = {32'd5, 32'd17, 32'd3, 32'd9};
    run_job(1'b1, 1, 0);
    ops = {32'hFFFF_FFFF, 32'h0000_0001};
    run_job(1'b0, 0, 0);
    ops = {32'd2, 32'd3};
    run_job(1'b0, 0, 0);
    ops = {32'h1234};
    run_job(1'b0, 10, 0);
    ops.delete();
    for (int i = 0; i < D; i++) ops.push_back($urandom);
    run_job(1'b0, 2, 0);
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, D);
      m = 1'($urandom_range(0, 1));
      ops.delete();
      for (int i = 0; i < n; i++) ops.push_back(j % 2 == 1 ? $urandom : $urandom_range(0, 1000));
      run_job(m, $urandom_range(0, 3), 0);
    end
    for (int i = 0; i < D; i++) send_op($urandom, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      chk("full_in_ready", W'(in_ready), 0);
      chk("full_busy", W'(busy), 1);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ops.delete();
    for (int i = 0; i < 16; i++) ops.push_back($urandom);
    run_job(1'b0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("reduce_busy", W'(busy), 1);
    chk("reduce_in_ready", W'(in_ready), 0);
    reset = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ops = {32'd7, 32'd8};
    run_job(1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
